// File: rtl/ahfp_norm.sv
// ahfp_norm: normalise-and-round stage of the ahfp adder/subtractor.
// Input capture, leading-zero detect, normalising shift, then round/pack,
// all under one global stall so the stages move in lock step.
module ahfp_norm (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_man,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        out_ovf,
    output logic        out_unf
);

    logic w_adv;

    // Input capture; keeps the leading-zero chain off the upstream adder path.
    logic        r_s0_valid;
    logic        r_s0_sign;
    logic [9:0]  r_s0_exp;
    logic [47:0] r_s0_man;

    // Detect stage registers.
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [9:0]  r_s1_exp;
    logic [47:0] r_s1_man;
    logic [5:0]  r_s1_lzc;
    logic        r_s1_zero;

    // Shift stage registers.
    logic               r_s2_valid;
    logic               r_s2_sign;
    logic signed [10:0] r_s2_e;
    logic [47:0]        r_s2_n;
    logic               r_s2_zero;

    // Output registers.
    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_ovf;
    logic        r_unf;

    logic [5:0]         w_lzc;
    logic [47:0]        w_s2_n;
    logic signed [10:0] w_s2_e;
    logic               w_rup;
    logic [23:0]        w_sum;
    logic signed [10:0] w_e_rnd;
    logic [31:0]        w_res;
    logic               w_ovf;
    logic               w_unf;

    assign w_adv     = !r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_ovf   = r_ovf;
    assign out_unf   = r_unf;

    // Capture the operand; a bubble enters whenever in_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_sign  <= 1'b0;
            r_s0_exp   <= '0;
            r_s0_man   <= '0;
        end else if (w_adv) begin
            r_s0_valid <= in_valid;
            r_s0_sign  <= in_sign;
            r_s0_exp   <= in_exp;
            r_s0_man   <= in_man;
        end
    end

    // Leading-zero count from bit 47; higher set bits override lower ones.
    always_comb begin
        w_lzc = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (r_s0_man[i]) begin
                w_lzc = 6'(47 - i);
            end
        end
    end

    // Detect stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_man   <= '0;
            r_s1_lzc   <= '0;
            r_s1_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= r_s0_valid;
            r_s1_sign  <= r_s0_sign;
            r_s1_exp   <= r_s0_exp;
            r_s1_man   <= r_s0_man;
            r_s1_lzc   <= w_lzc;
            r_s1_zero  <= (r_s0_man == 48'd0);
        end
    end

    // Normalising shift and exponent adjust in 11-bit signed form (cannot wrap).
    always_comb begin
        w_s2_n = r_s1_man << r_s1_lzc;
        w_s2_e = $signed({r_s1_exp[9], r_s1_exp}) + 11'sd1 - $signed({5'd0, r_s1_lzc});
    end

    // Shift stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_e     <= '0;
            r_s2_n     <= '0;
            r_s2_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_e     <= w_s2_e;
            r_s2_n     <= w_s2_n;
            r_s2_zero  <= r_s1_zero;
        end
    end

    // Round to nearest even, then saturate / flush and pack.
    always_comb begin
        w_res   = 32'd0;
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        w_rup   = r_s2_n[23] & ((|r_s2_n[22:0]) | r_s2_n[24]);
        w_sum   = {1'b0, r_s2_n[46:24]} + 24'(w_rup);
        // A mantissa carry leaves the fraction bits at zero.
        w_e_rnd = r_s2_e + $signed({10'd0, w_sum[23]});
        if (r_s2_zero) begin
            w_res = 32'd0;
        end else if (w_e_rnd >= 11'sd255) begin
            w_res = {r_s2_sign, 8'hFF, 23'd0};
            w_ovf = 1'b1;
        end else if (w_e_rnd <= 11'sd0) begin
            w_res = {r_s2_sign, 31'd0};
            w_unf = 1'b1;
        end else begin
            w_res = {r_s2_sign, w_e_rnd[7:0], w_sum[22:0]};
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            r_result    <= w_res;
            r_ovf       <= w_ovf & r_s2_valid;
            r_unf       <= w_unf & r_s2_valid;
        end
    end

endmodule

// File: tb/tb_ahfp_norm.sv
// Self-checking bench for ahfp_norm: directed vectors, random streaming against
// a value-level rounding model, backpressure and mid-flight reset.
module tb_ahfp_norm;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_ovf;
    logic        out_unf;

    int n_tests = 0;
    int n_fail  = 0;

    ahfp_norm dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    // Value-level model: locate the leading one, keep 24 significant bits,
    // compare the discarded remainder with half an ulp, then range-check.
    function automatic logic [33:0] model(input logic s, input logic [9:0] ex,
                                          input logic [47:0] m);
        int              p;
        int              e;
        longint unsigned mm;
        longint unsigned rem;
        longint unsigned half;
        longint unsigned full;
        logic [31:0]     r;
        if (m == 48'd0) return 34'd0;
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        e    = int'($signed(ex)) + p - 46;
        full = longint'(m);
        if (p > 23) begin
            mm   = full >> (p - 23);
            rem  = full - (mm << (p - 23));
            half = 64'd1 << (p - 24);
            if (rem > half || (rem == half && mm[0])) mm = mm + 1;
        end else begin
            mm = full << (23 - p);
        end
        if (mm == 64'd16777216) begin
            mm = mm >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, s, 31'd0};
        r = {s, 8'(e), mm[22:0]};
        return {2'b00, r};
    endfunction

    task automatic gen_operand(output logic s, output logic [9:0] ex, output logic [47:0] m);
        logic [47:0] raw;
        raw = {16'($urandom), 32'($urandom)};
        m   = raw >> $urandom_range(0, 48);
        if ($urandom_range(0, 5) == 0) m = {m[47:24], 1'b1, 23'd0};
        s  = 1'($urandom);
        ex = 10'($urandom);
        case ($urandom_range(0, 9))
            0: ex = 10'h200;
            1: ex = 10'h1FF;
            2: ex = 10'd127;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || result !== 32'd0 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%h o=%b u=%b, want 0 0 0 0",
                     out_valid, result, out_ovf, out_unf);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    logic [47:0] d_man [9] = '{48'h400000000000, 48'h800000800000, 48'h800001800000,
                               48'hFFFFFF800000, 48'h000000000001, 48'h400000000000,
                               48'h400000000000, 48'h000000000000, 48'h000000000001};
    logic [9:0]  d_exp [9] = '{10'd127, 10'd126, 10'd126, 10'd126, 10'd127, 10'd255,
                               10'd0, 10'd0, 10'h200};
    logic        d_sgn [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] d_res [9] = '{32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h40000000,
                               32'h28800000, 32'hFF800000, 32'h80000000, 32'h00000000,
                               32'h00000000};
    logic [1:0]  d_flg [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01};

    task automatic test_directed();
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_sign   = d_sgn[v];
            in_exp    = d_exp[v];
            in_man    = d_man[v];
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                n_tests++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_early v%0d c%0d: out_valid=%b, want 0", v, c, out_valid);
                end
            end
            @(negedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || result !== d_res[v] || {out_ovf, out_unf} !== d_flg[v]) begin
                n_fail++;
                $display("FAIL directed v%0d: got v=%b r=%h ou=%b%b, want v=1 r=%h ou=%b",
                         v, out_valid, result, out_ovf, out_unf, d_res[v], d_flg[v]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int n);
        logic [33:0] q[$];
        logic [33:0] exp_v;
        logic [31:0] held;
        logic        was_held;
        int          sent;
        int          got;
        int          cyc;
        logic        s;
        logic [9:0]  ex;
        logic [47:0] m;
        sent = 0; got = 0; cyc = 0; was_held = 1'b0; held = '0;
        while ((sent < n || got < sent) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (sent < n && $urandom_range(0, 3) != 0) begin
                gen_operand(s, ex, m);
                in_valid = 1'b1; in_sign = s; in_exp = ex; in_man = m;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (was_held && out_valid) begin
                n_tests++;
                if (result !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: result %h, want %h", result, held);
                end
            end
            was_held = out_valid && !out_ready;
            held     = result;
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_extra: unexpected result %h", result);
                end else begin
                    exp_v = q.pop_front();
                    got++;
                    if ({out_ovf, out_unf, result} !== exp_v) begin
                        n_fail++;
                        $display("FAIL random #%0d: got ou=%b%b r=%h, want ou=%b r=%h",
                                 got, out_ovf, out_unf, result, exp_v[33:32], exp_v[31:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_sign, in_exp, in_man));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != n) begin
            n_fail++;
            $display("FAIL random_count: got %0d results, want %0d", got, n);
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] q[$];
        logic [33:0] exp_v;
        logic [31:0] hold;
        logic        s [6];
        logic [9:0]  ex [6];
        logic [47:0] m [6];
        int          sent;
        int          got;
        int          stall;
        int          cyc;
        logic        seen;
        for (int i = 0; i < 6; i++) gen_operand(s[i], ex[i], m[i]);
        sent = 0; got = 0; stall = 0; cyc = 0; seen = 1'b0; hold = '0;
        while (got < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_sign = s[sent]; in_exp = ex[sent]; in_man = m[sent];
            end
            #1;
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 5;
                hold  = result;
            end
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                n_tests++;
                if (result !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL backpressure: r=%h rdy=%b v=%b, want r=%h rdy=0 v=1",
                             result, in_ready, out_valid, hold);
                end
                stall--;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected result %h", result);
                end else begin
                    exp_v = q.pop_front();
                    if ({out_ovf, out_unf, result} !== exp_v) begin
                        n_fail++;
                        $display("FAIL b2b #%0d: got ou=%b%b r=%h, want ou=%b r=%h",
                                 got, out_ovf, out_unf, result, exp_v[33:32], exp_v[31:0]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_sign, in_exp, in_man));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 6 || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, %0d left, want 6 and 0", got, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b0; in_exp = 10'd127; in_man = 48'h400000000000;
        @(negedge clk);
        in_man    = 48'h600000000000;
        @(negedge clk);
        in_valid  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_fill: out_valid=%b, want 1", out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b, want 0", out_valid);
        end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_spurious c%0d: out_valid=%b, want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(300);
        test_back_to_back();
        test_reset_midflight();
        test_random(50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
